// File: rtl/mat4x2_mac_stream.sv
// mat4x2_mac_stream
// Streaming 4x2 * 2x2 unsigned matrix multiply using one time-shared
// multiply-accumulate. Operands arrive one element per handshake in the
// order A0..A7, B0..B3; the eight results S0..S7 (row-major) leave one
// element per handshake.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand element valid
//   in_ready   block accepts an operand element (LOAD only)
//   in_data    operand element
//   out_valid  result element valid (SEND only)
//   out_ready  downstream accepts result element
//   out_data   result element S[out_idx]
//   out_idx    result index 0..7
//   out_last   high together with S7
//   busy       high while computing or sending
module mat4x2_mac_stream #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2*DATA_W+1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_CALC = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t            state_q;
  logic [3:0]        load_cnt_q;
  logic [3:0]        step_q;
  logic [2:0]        idx_q;

  logic [DATA_W-1:0]   a_q [8];
  logic [DATA_W-1:0]   b_q [4];
  logic [2*DATA_W-1:0] acc_q;
  logic [RES_W-1:0]    res_q [8];

  logic                load_fire;
  logic [1:0]          row;
  logic                col;
  logic                term;
  logic [DATA_W-1:0]   mul_x;
  logic [DATA_W-1:0]   mul_y;
  logic [2*DATA_W-1:0] prod;
  logic [RES_W-1:0]    sum;

  // in_ready is forced low while rst is held so no operand can be taken
  // in a reset cycle; it rises in the very first cycle rst is released.
  assign in_ready  = (state_q == S_LOAD) && !rst;
  assign load_fire = in_valid && in_ready;

  // Step 2k / 2k+1 computes S(k): k selects row r = k/2 and column c = k%2,
  // the step LSB selects which of the two product terms is formed.
  always_comb begin
    row   = step_q[3:2];
    col   = step_q[1];
    term  = step_q[0];
    mul_x = term ? a_q[{row, 1'b1}] : a_q[{row, 1'b0}];
    mul_y = term ? b_q[{1'b1, col}] : b_q[{1'b0, col}];
    prod  = {{DATA_W{1'b0}}, mul_x} * {{DATA_W{1'b0}}, mul_y};
    sum   = RES_W'(acc_q) + RES_W'(prod);
  end

  // Control: state, load counter, MAC step and output index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      load_cnt_q <= '0;
      step_q     <= '0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (load_fire) begin
            if (load_cnt_q == 4'd11) begin
              load_cnt_q <= '0;
              step_q     <= '0;
              state_q    <= S_CALC;
            end else begin
              load_cnt_q <= load_cnt_q + 4'd1;
            end
          end
        end
        S_CALC: begin
          step_q <= step_q + 4'd1;
          if (step_q == 4'd15) begin
            idx_q   <= '0;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (idx_q == 3'd7) begin
              idx_q      <= '0;
              load_cnt_q <= '0;
              state_q    <= S_LOAD;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Datapath: operand capture and MAC; never reset, each frame rewrites it.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      if (load_cnt_q < 4'd8) a_q[load_cnt_q[2:0]] <= in_data;
      else                   b_q[load_cnt_q[1:0]] <= in_data;
    end
    if (state_q == S_CALC) begin
      if (!term) acc_q <= prod;
      else       res_q[step_q[3:1]] <= sum;
    end
  end

  assign out_valid = (state_q == S_SEND);
  assign out_data  = out_valid ? res_q[idx_q] : '0;
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == 3'd7);
  assign busy      = (state_q != S_LOAD);

endmodule

// File: tb/tb_mat4x2_mac_stream.sv
module tb_mat4x2_mac_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mat4x2_mac_stream #(.DATA_W(4), .RES_W(9)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  // Element i of a frame sits at ops[4*i +: 4] (A0..A7, B0..B3).
  localparam logic [47:0] F1 = {4'd3,4'd1,4'd5,4'd6, 4'd3,4'd2,4'd1,4'd2, 4'd2,4'd2,4'd2,4'd1};
  localparam logic [47:0] F2 = {4'd3,4'd1,4'd5,4'd6, 4'd6,4'd2,4'd1,4'd2, 4'd2,4'd2,4'd2,4'd7};
  // Result k sits at res[9*k +: 9].
  localparam logic [71:0] E1 = {9'd19,9'd15,9'd13,9'd13,9'd16,9'd14,9'd11,9'd8};
  localparam logic [71:0] E2 = {9'd28,9'd18,9'd13,9'd13,9'd16,9'd14,9'd41,9'd44};

  // Reference: plain matrix product S = A(4x2) * B(2x2), row-major.
  function automatic logic [71:0] model(input logic [47:0] ops);
    int a [8];
    int b [4];
    int s;
    logic [71:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) a[i] = int'(ops[4*i +: 4]);
    for (int i = 0; i < 4; i++) b[i] = int'(ops[32 + 4*i +: 4]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 2; c++) begin
        s = a[2*r] * b[c] + a[2*r+1] * b[2+c];
        res[(2*r+c)*9 +: 9] = 9'(s);
      end
    return res;
  endfunction

  task automatic load_frame(input logic [47:0] ops, input int n_ops, input int gap_pct);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < n_ops && cyc < 500) begin
      @(negedge clk);
      cyc++;
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = in_valid ? ops[idx*4 +: 4] : 4'($urandom);
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    n_tests++;
    if (idx !== n_ops) begin
      n_fail++;
      $display("FAIL load_accept: accepted %0d operands, required %0d", idx, n_ops);
    end
  endtask

  task automatic check_latency(input bit junk);
    int rise = 0;
    bit bad_ctrl = 0;
    for (int k = 1; k <= 40 && rise == 0; k++) begin
      @(negedge clk);
      if (out_valid) rise = k;
      else if (in_ready || !busy) bad_ctrl = 1;
      in_valid  = junk;
      in_data   = 4'($urandom);
      out_ready = 1'b0;
      if (rise == 0) @(posedge clk);
    end
    n_tests++;
    if (rise !== 17) begin
      n_fail++;
      $display("FAIL latency: out_valid rose %0d cycles after last operand, required 17", rise);
    end
    n_tests++;
    if (bad_ctrl) begin
      n_fail++;
      $display("FAIL calc_ctrl: in_ready high or busy low during calculation, required in_ready=0 busy=1");
    end
  endtask

  task automatic receive_frame(input logic [71:0] expv, input int n_stop,
                               input int rdy_pct, input bit junk);
    int n = 0;
    int cyc = 0;
    bit stall = 0;
    logic [8:0] pd = '0;
    logic [2:0] pi = '0;
    while (n < n_stop && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== pd || out_idx !== pi) begin
          n_fail++;
          $display("FAIL hold: valid=%0b data=%0d idx=%0d, required valid=1 data=%0d idx=%0d",
                   out_valid, out_data, out_idx, pd, pi);
        end
      end
      out_ready = ($urandom_range(99) < rdy_pct);
      in_valid  = junk;
      in_data   = 4'($urandom);
      stall = out_valid && !out_ready;
      pd = out_data;
      pi = out_idx;
      if (out_valid && out_ready) begin
        n_tests++;
        if (out_data !== expv[n*9 +: 9] || out_idx !== 3'(n) || out_last !== (n == 7)) begin
          n_fail++;
          $display("FAIL result: got S%0d=%0d last=%0b, required S%0d=%0d last=%0b",
                   out_idx, out_data, out_last, n, expv[n*9 +: 9], (n == 7));
        end
        n++;
      end
      @(posedge clk);
    end
    n_tests++;
    if (n !== n_stop) begin
      n_fail++;
      $display("FAIL recv_count: received %0d results, required %0d", n, n_stop);
    end
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    if (n_stop == 8) begin
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reload: in_ready=%0b out_valid=%0b busy=%0b, required 1 0 0",
                 in_ready, out_valid, busy);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 9'd0 ||
        out_idx !== 3'd0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: rdy=%0b vld=%0b data=%0d idx=%0d last=%0b busy=%0b, required 0 0 0 0 0 0",
               in_ready, out_valid, out_data, out_idx, out_last, busy);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%0b, required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 9'd0 ||
        out_idx !== 3'd0 || out_last !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: rdy=%0b vld=%0b data=%0d idx=%0d last=%0b busy=%0b, required 1 0 0 0 0 0",
               in_ready, out_valid, out_data, out_idx, out_last, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_frame1();
    load_frame(F1, 12, 0);
    check_latency(1'b0);
    receive_frame(E1, 8, 100, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_frame(F2, 12, 0);
    check_latency(1'b0);
    receive_frame(E2, 8, 100, 1'b0);
  endtask

  task automatic test_extremes();
    load_frame({12{4'hF}}, 12, 0);
    check_latency(1'b0);
    receive_frame({8{9'd450}}, 8, 100, 1'b0);
    load_frame(48'd0, 12, 0);
    check_latency(1'b0);
    receive_frame(72'd0, 8, 100, 1'b0);
  endtask

  task automatic test_stalls();
    load_frame(F1, 12, 40);
    check_latency(1'b0);
    receive_frame(E1, 8, 45, 1'b0);
  endtask

  task automatic test_reset_mid();
    load_frame(F1, 5, 0);
    do_reset();
    load_frame(F1, 12, 0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_calc: busy=%0b out_valid=%0b, required 1 0", busy, out_valid);
    end
    do_reset();
    load_frame(F1, 12, 0);
    check_latency(1'b0);
    receive_frame(E1, 4, 100, 1'b0);
    do_reset();
    load_frame(F1, 12, 0);
    check_latency(1'b0);
    receive_frame(E1, 8, 100, 1'b0);
  endtask

  task automatic test_junk();
    load_frame(F2, 12, 0);
    check_latency(1'b1);
    receive_frame(E2, 8, 60, 1'b1);
  endtask

  task automatic test_random();
    logic [47:0] ops;
    for (int f = 0; f < 4; f++) begin
      ops = {$urandom, $urandom};
      load_frame(ops, 12, 30);
      check_latency(1'b0);
      receive_frame(model(ops), 8, 70, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_frame1();
    test_back_to_back();
    test_extremes();
    test_stalls();
    test_reset_mid();
    test_junk();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
